lfo_rate_ctrl: RTL and testbench
================================

LFO_RATE_CTRL -- requirements
Module: lfo_rate_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, width of the triangle generator output it controls.
REQ-002 SHALL have parameter DIV_W, default 16, width of the rate divider.
REQ-003 SHALL have parameter DRAIN_THR, default 2; drain completes when wav < DRAIN_THR.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_on  in  1  user LFO enable level.
REQ-007 rate  in  DIV_W  step interval minus one, in sample ticks.
REQ-008 smp_tick  in  1  one-cycle audio sample-rate strobe.
REQ-009 wav  in  N  current generator output (feedback).
REQ-010 sync  in  1  one-cycle phase-restart strobe (see Configuration).
REQ-011 gen_en  out  1  enable to generator; low clears generator.
REQ-012 gen_nxt  out  1  one-cycle step strobe to generator.
REQ-013 busy  out  1  high in any state except IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, RESTART; registered outputs.
REQ-015 IDLE: gen_en=0, gen_nxt=0, divider count cnt held at 0; req_on=1 -> RUN next cycle.
REQ-016 RUN: gen_en=1; on smp_tick with cnt >= rate, gen_nxt=1 for exactly one cycle, cnt<=0; on smp_tick otherwise cnt<=cnt+1; no tick -> cnt holds.
REQ-017 Step period SHALL be rate+1 sample ticks; rate=0 steps on every smp_tick.
REQ-018 Rate lowered below cnt mid-interval SHALL fire gen_nxt on the next smp_tick (>= compare), no wrap through 2^DIV_W.
REQ-019 gen_nxt SHALL assert one cycle after the qualifying smp_tick cycle and never in two consecutive cycles.
REQ-020 RUN with req_on=0 -> DRAIN; if wav < DRAIN_THR at that moment -> IDLE directly.
REQ-021 DRAIN: gen_en=1, stepping continues at programmed rate until wav < DRAIN_THR, then IDLE (gen_en=0 next cycle).
REQ-022 DRAIN timeout: after 2^N+1 gen_nxt pulses in DRAIN without reaching threshold -> IDLE forced.
REQ-023 req_on=1 during DRAIN SHALL return to RUN without clearing cnt or wave.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, cnt=0, drain counter=0, gen_en=0, gen_nxt=0, busy=0.
REQ-026 Deassertion mid-tick SHALL not produce gen_nxt; first step requires a full rate+1 tick interval from RUN entry.

Configuration
REQ-027 Macro LFO_SYNC_RESTART_EN SHALL gate the sync restart feature.
REQ-028 Defined: sync=1 in RUN -> RESTART for one cycle (gen_en=0, gen_nxt=0, cnt<=0), then RUN; sync in IDLE/DRAIN ignored; sync coincident with req_on falling -> DRAIN takes priority.
REQ-029 Not defined: sync port present but ignored; RESTART state unreachable; behaviour otherwise identical.

Verification
REQ-030 rate=3, req_on=1, smp_tick every 4 clk -> gen_nxt every 16 clk, one cycle wide, gen_en=1, busy=1.
REQ-031 rate=0 -> gen_nxt one cycle after each smp_tick; rate changed 10->2 with cnt=7 -> gen_nxt after next smp_tick.
REQ-032 req_on drop with wav=100, N=8 -> DRAIN, gen_en stays 1 until wav=1, then IDLE, gen_en=0, busy=0.
REQ-033 req_on drop with wav=0 -> IDLE next cycle, no gen_nxt issued.
REQ-034 With LFO_SYNC_RESTART_EN: sync in RUN -> gen_en=0 exactly one cycle, cnt=0, next gen_nxt rate+1 ticks later; without macro: no effect.
REQ-035 rst_n asserted in DRAIN between clock edges -> outputs zero immediately; after release stays IDLE until req_on=1.

Source files
------------

// File: rtl/lfo_rate_ctrl.sv
// lfo_rate_ctrl: run/drain/restart sequencer and rate divider for a triangle LFO.
// Optional sync phase restart is enabled by defining LFO_SYNC_RESTART_EN.
module lfo_rate_ctrl #(
  parameter int N         = 8,
  parameter int DIV_W     = 16,
  parameter int DRAIN_THR = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_on,
  input  logic [DIV_W-1:0] rate,
  input  logic             smp_tick,
  input  logic [N-1:0]     wav,
  input  logic             sync,
  output logic             gen_en,
  output logic             gen_nxt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_RESTART
  } state_t;

  localparam logic [N-1:0] LP_THR    = N'(DRAIN_THR);
  localparam int           LP_DMAX_I = (1 << N) + 1;
  localparam logic [N:0]   LP_DMAX   = LP_DMAX_I[N:0];

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [N:0]       r_dcnt;
  logic             r_gen_en;
  logic             r_gen_nxt;

  logic w_hit;
  logic w_inc;
  logic w_low;
  logic w_sync;

  // A step needs a tick at or past the programmed interval; no back-to-back strobes
  assign w_hit = smp_tick && (r_cnt >= rate) && !r_gen_nxt;
  // Only count up while below rate so the counter can never wrap
  assign w_inc = smp_tick && (r_cnt < rate);
  assign w_low = wav < LP_THR;

`ifdef LFO_SYNC_RESTART_EN
  assign w_sync = sync;
`else
  logic w_unused_sync;
  assign w_unused_sync = sync;
  assign w_sync = 1'b0;
`endif

  // Sequencer, divider and drain-step counter with registered generator controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dcnt    <= '0;
      r_gen_en  <= 1'b0;
      r_gen_nxt <= 1'b0;
    end else begin
      r_gen_nxt <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_dcnt <= '0;
          if (req_on) begin
            r_state  <= S_RUN;
            r_gen_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (!req_on) begin
            r_dcnt <= '0;
            if (w_low) begin
              r_state  <= S_IDLE;
              r_gen_en <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (w_sync) begin
            r_state  <= S_RESTART;
            r_gen_en <= 1'b0;
            r_cnt    <= '0;
          end else if (w_hit) begin
            r_gen_nxt <= 1'b1;
            r_cnt     <= '0;
          end else if (w_inc) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (req_on) begin
            r_state <= S_RUN;
            r_dcnt  <= '0;
          end else if (w_low || (r_dcnt >= LP_DMAX)) begin
            r_state  <= S_IDLE;
            r_gen_en <= 1'b0;
            r_cnt    <= '0;
            r_dcnt   <= '0;
          end else if (w_hit) begin
            r_gen_nxt <= 1'b1;
            r_cnt     <= '0;
            r_dcnt    <= r_dcnt + 1'b1;
          end else if (w_inc) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESTART: begin
          r_state  <= S_RUN;
          r_gen_en <= 1'b1;
          r_cnt    <= '0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_gen_en <= 1'b0;
          r_cnt    <= '0;
          r_dcnt   <= '0;
        end
      endcase
    end
  end

  assign gen_en  = r_gen_en;
  assign gen_nxt = r_gen_nxt;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_lfo_rate_ctrl.sv
// tb_lfo_rate_ctrl: scoreboard bench for lfo_rate_ctrl.
// Expected gen_nxt cycles are queued by stimulus and popped by a monitor.
module tb_lfo_rate_ctrl;
  localparam int N  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_on;
  logic [DW-1:0] rate;
  logic          smp_tick;
  logic [N-1:0]  wav;
  logic          sync;
  logic          gen_en;
  logic          gen_nxt;
  logic          busy;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int e;

  lfo_rate_ctrl #(.N(N), .DIV_W(DW), .DRAIN_THR(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_on(req_on), .rate(rate),
    .smp_tick(smp_tick), .wav(wav), .sync(sync),
    .gen_en(gen_en), .gen_nxt(gen_nxt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index of the most recent rising edge
  always @(posedge clk) cyc++;

  // Monitor: every gen_nxt pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (gen_nxt) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL gen_nxt_unexpected: pulse at cycle %0d, none required", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL gen_nxt_cycle: pulse at cycle %0d, required %0d", cyc, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        n_chk++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL gen_nxt_missing: no pulse at cycle %0d, required %0d", cyc, e);
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, req);
    end
  endtask

  task automatic nxt(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tk(input bit fire);
    smp_tick = 1'b1;
    if (fire) exp_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    smp_tick = 1'b0;
  endtask

  task automatic tkp(input bit fire, input int gap);
    tk(fire);
    nxt(gap);
  endtask

  initial begin
    rst_n = 1'b0; req_on = 1'b0; smp_tick = 1'b0;
    sync = 1'b0; rate = '0; wav = '0;
    nxt(2);
    chk("rst_gen_en", gen_en, 1'b0);
    chk("rst_gen_nxt", gen_nxt, 1'b0);
    chk("rst_busy", busy, 1'b0);

    #3 smp_tick = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1 smp_tick = 1'b0;
    chk("rel_busy", busy, 1'b0);
    nxt(1);

    rate = 16'd3; req_on = 1'b1;
    nxt(1);
    chk("run_gen_en", gen_en, 1'b1);
    chk("run_busy", busy, 1'b1);
    for (int i = 1; i <= 12; i++) tkp(i % 4 == 0, 3);
    chk("run_gen_en_hold", gen_en, 1'b1);

    rate = 16'd0;
    for (int i = 0; i < 3; i++) tkp(1'b1, 1);

    rate = 16'd10;
    for (int i = 0; i < 7; i++) tkp(1'b0, 1);
    rate = 16'd2;
    tkp(1'b1, 1);
    for (int i = 1; i <= 3; i++) tkp(i == 3, 1);

    wav = 8'd100; req_on = 1'b0;
    nxt(1);
    chk("drain_gen_en", gen_en, 1'b1);
    chk("drain_busy", busy, 1'b1);
    for (int i = 1; i <= 3; i++) tkp(i == 3, 1);
    chk("drain_step_gen_en", gen_en, 1'b1);
    wav = 8'd1;
    nxt(1);
    chk("drain_done_gen_en", gen_en, 1'b0);
    chk("drain_done_busy", busy, 1'b0);

    wav = 8'd100; req_on = 1'b1;
    nxt(1);
    tkp(1'b0, 1);
    tkp(1'b0, 1);
    req_on = 1'b0;
    nxt(1);
    chk("resume_drain_busy", busy, 1'b1);
    req_on = 1'b1;
    nxt(1);
    chk("resume_gen_en", gen_en, 1'b1);
    tkp(1'b1, 1);

    rate = 16'd0; wav = 8'd0; req_on = 1'b0; smp_tick = 1'b1;
    nxt(1);
    smp_tick = 1'b0;
    chk("low_idle_busy", busy, 1'b0);
    chk("low_idle_gen_en", gen_en, 1'b0);

    rate = 16'd1; wav = 8'd100; req_on = 1'b1;
    nxt(1);
    tkp(1'b0, 1);
    sync = 1'b1;
    nxt(1);
    sync = 1'b0;
`ifdef LFO_SYNC_RESTART_EN
    chk("sync_gen_en_low", gen_en, 1'b0);
    chk("sync_busy", busy, 1'b1);
    nxt(1);
    chk("sync_gen_en_back", gen_en, 1'b1);
    tkp(1'b0, 1);
    tkp(1'b1, 1);
`else
    chk("sync_ignored_gen_en", gen_en, 1'b1);
    tkp(1'b1, 1);
`endif

    rate = 16'd0; req_on = 1'b0;
    nxt(1);
    chk("to_drain_busy", busy, 1'b1);
    for (int i = 0; i < 256; i++) tkp(1'b1, 1);
    chk("to_busy_256", busy, 1'b1);
    tk(1'b1);
    chk("to_busy_257", busy, 1'b1);
    nxt(1);
    chk("to_idle_busy", busy, 1'b0);
    chk("to_idle_gen_en", gen_en, 1'b0);

    req_on = 1'b1;
    nxt(1);
    req_on = 1'b0;
    nxt(1);
    chk("rd_drain_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rd_gen_en", gen_en, 1'b0);
    chk("rd_busy", busy, 1'b0);
    chk("rd_gen_nxt", gen_nxt, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nxt(3);
    chk("rd_stay_idle", busy, 1'b0);
    req_on = 1'b1;
    nxt(1);
    chk("rd_run_busy", busy, 1'b1);

    nxt(3);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: %0d pulses outstanding, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
